tape_char_monitor: RTL and testbench

Simulation-side consumer placed directly downstream of the photo tape reader model. It watches the five photo lines and the wait-for-tape line, re-frames the 5 ms character cells on tick_ms, and checks each cell's shape. It pushes every decoded character, tagged with tape direction, into a small FIFO that the testbench drains through a valid/ready handshake. It also keeps a character count, a stop-code detector and sticky error flags for self-checking benches.

---
 rtl/tape_char_monitor.sv | 158 +++++++++++++++
 tb/tb_tape_char_monitor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tape_char_monitor.sv
// rtl/tape_char_monitor.sv - photo tape character framing monitor with capture FIFO
module tape_char_monitor #(
    parameter int             DEPTH     = 16,
    parameter logic [4:0]     STOP_CODE = 5'b10000,
    parameter int             CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_ms,
    input  logic                       PL6_1_PHOTO1,
    input  logic                       PL6_2_PHOTO2,
    input  logic                       PL6_4_PHOTO3,
    input  logic                       PL6_5_PHOTO4,
    input  logic                       PL6_7_PHOTO5,
    input  logic                       PL6_18_WAIT_FOR_TAPE,
    input  logic                       PL6_9_PHOTO_TAPE_FWD,
    input  logic                       clr_status,
    output logic                       char_valid,
    input  logic                       char_ready,
    output logic [5:0]                 char_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           char_total,
    output logic                       match_seen,
    output logic                       overflow,
    output logic                       frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t      state, state_nxt;
    logic [2:0]  phase, phase_nxt;
    logic        dir;
    logic [4:0]  cap;
    logic        bad;
    logic [4:0]  code;
    logic        tape_wait;

    logic        arm;
    logic        cell_tick;
    logic        load_cap;
    logic        mism;
    logic        blank_err;
    logic        commit;

    logic [5:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic        push, pop;

    assign code      = {PL6_1_PHOTO1, PL6_2_PHOTO2, PL6_4_PHOTO3, PL6_5_PHOTO4, PL6_7_PHOTO5};
    assign tape_wait = PL6_18_WAIT_FOR_TAPE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= 3'd0;
        end else if (tick_ms) begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        if (!tape_wait) begin
            state_nxt = IDLE;
            phase_nxt = 3'd0;
        end else if (state == IDLE) begin
            state_nxt = ARMED;
            phase_nxt = 3'd0;
        end else begin
            phase_nxt = (phase == 3'd5) ? 3'd1 : phase + 3'd1;
        end
    end

    // Actions are keyed on the phase being entered on this tick.
    always_comb begin
        arm       = tick_ms && tape_wait && (state == IDLE);
        cell_tick = tick_ms && tape_wait && (state == ARMED);
        load_cap  = cell_tick && (phase_nxt == 3'd1);
        mism      = cell_tick && ((phase_nxt == 3'd2) || (phase_nxt == 3'd3)) && (code != cap);
        blank_err = cell_tick && (phase_nxt >= 3'd4) && (code != 5'd0);
        commit    = cell_tick && (phase_nxt == 3'd3) && !bad && !mism;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir <= 1'b0;
            cap <= 5'd0;
            bad <= 1'b0;
        end else begin
            if (arm)
                dir <= PL6_9_PHOTO_TAPE_FWD;
            if (load_cap) begin
                cap <= code;
                bad <= 1'b0;
            end else if (mism) begin
                bad <= 1'b1;
            end
        end
    end

    assign char_valid = (fifo_count != '0);
    assign char_data  = char_valid ? mem[rptr] : 6'd0;
    assign pop        = char_valid && char_ready;
    assign push       = commit && ((fifo_count != FULL_CNT) || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {dir, cap};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A clear coinciding with a commit leaves the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_total <= '0;
            match_seen <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else if (clr_status) begin
            char_total <= commit ? CNT_W'(1) : '0;
            match_seen <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (commit && (char_total != '1))
                char_total <= char_total + 1'b1;
            if (commit && (cap == STOP_CODE))
                match_seen <= 1'b1;
            if (commit && !push)
                overflow <= 1'b1;
            if (mism || blank_err)
                frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tape_char_monitor.sv
// tb/tb_tape_char_monitor.sv - directed self-checking bench for tape_char_monitor
module tb_tape_char_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_ms = 1'b0;
    logic [4:0]  code = 5'd0;
    logic        tape_wait = 1'b0;
    logic        fwd = 1'b1;
    logic        clr_status = 1'b0;
    logic        char_ready = 1'b0;
    logic        char_valid;
    logic [5:0]  char_data;
    logic [4:0]  fifo_count;
    logic [15:0] char_total;
    logic        match_seen, overflow, frame_err;

    int n_checks = 0;
    int n_fails  = 0;
    logic [5:0] popped [$];

    tape_char_monitor dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms),
        .PL6_1_PHOTO1(code[4]), .PL6_2_PHOTO2(code[3]), .PL6_4_PHOTO3(code[2]),
        .PL6_5_PHOTO4(code[1]), .PL6_7_PHOTO5(code[0]),
        .PL6_18_WAIT_FOR_TAPE(tape_wait), .PL6_9_PHOTO_TAPE_FWD(fwd),
        .clr_status(clr_status), .char_valid(char_valid), .char_ready(char_ready),
        .char_data(char_data), .fifo_count(fifo_count), .char_total(char_total),
        .match_seen(match_seen), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && char_valid && char_ready)
            popped.push_back(char_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick(input logic w, input logic [4:0] c);
        @(negedge clk);
        tape_wait = w;
        code      = c;
        tick_ms   = 1'b1;
        @(negedge clk);
        tick_ms   = 1'b0;
        idle(2);
    endtask

    task automatic send_cell(input logic [4:0] c);
        do_tick(1'b1, c);
        do_tick(1'b1, c);
        do_tick(1'b1, c);
        do_tick(1'b1, 5'd0);
        do_tick(1'b1, 5'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    initial begin
        idle(3);
        check("reset_valid", char_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_total", char_total, 0);
        check("reset_flags", {match_seen, overflow, frame_err}, 0);
        check("reset_data", char_data, 0);
        rst = 1'b0;

        // Forward run, consumer always ready
        char_ready = 1'b1;
        fwd = 1'b1;
        do_tick(1'b1, 5'd0);
        send_cell(5'h15);
        send_cell(5'h0A);
        send_cell(5'h00);
        do_tick(1'b0, 5'd0);
        idle(3);
        check("fwd_npop", popped.size(), 3);
        check("fwd_c0", popped[0], 6'h35);
        check("fwd_c1", popped[1], 6'h2A);
        check("fwd_c2", popped[2], 6'h20);
        check("fwd_total", char_total, 3);
        check("fwd_ferr", frame_err, 0);
        check("fwd_match", match_seen, 0);

        // Reverse run, stop code
        fwd = 1'b0;
        do_tick(1'b1, 5'd0);
        send_cell(5'h10);
        do_tick(1'b0, 5'd0);
        idle(3);
        check("rev_npop", popped.size(), 4);
        check("rev_c0", popped[3], 6'h10);
        check("rev_match", match_seen, 1);
        pulse_clr();
        idle(1);
        check("clr_match", match_seen, 0);
        check("clr_total", char_total, 0);

        // Overflow: 17 characters into 16 entries
        popped.delete();
        char_ready = 1'b0;
        fwd = 1'b1;
        do_tick(1'b1, 5'd0);
        for (int i = 1; i <= 17; i++) send_cell(5'(i));
        do_tick(1'b0, 5'd0);
        idle(2);
        check("ovf_count", fifo_count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_total", char_total, 17);
        check("ovf_head", char_data, 6'h21);
        char_ready = 1'b1;
        idle(20);
        check("ovf_npop", popped.size(), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("ovf_drain%0d", i), popped[i], 6'h20 | 6'(i + 1));
        check("ovf_empty", char_valid, 0);

        // Full FIFO with a pop on the commit clock
        pulse_clr();
        popped.delete();
        char_ready = 1'b0;
        do_tick(1'b1, 5'd0);
        for (int i = 0; i < 16; i++) send_cell(5'(i + 2));
        check("full_count", fifo_count, 16);
        do_tick(1'b1, 5'h1F);
        do_tick(1'b1, 5'h1F);
        @(negedge clk);
        code = 5'h1F;
        tick_ms = 1'b1;
        char_ready = 1'b1;
        @(negedge clk);
        tick_ms = 1'b0;
        char_ready = 1'b0;
        check("fullpop_count", fifo_count, 16);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_total", char_total, 17);
        check("fullpop_popped", popped.size() == 1 ? popped[0] : 6'h3F, 6'h22);
        do_tick(1'b0, 5'd0);
        char_ready = 1'b1;
        idle(20);
        check("fullpop_last", popped[popped.size()-1], 6'h3F);

        // Glitch in phase 2
        pulse_clr();
        popped.delete();
        do_tick(1'b1, 5'd0);
        do_tick(1'b1, 5'h03);
        do_tick(1'b1, 5'h07);
        do_tick(1'b1, 5'h07);
        do_tick(1'b1, 5'd0);
        do_tick(1'b1, 5'd0);
        do_tick(1'b0, 5'd0);
        idle(2);
        check("glitch_ferr", frame_err, 1);
        check("glitch_total", char_total, 0);
        check("glitch_npop", popped.size(), 0);

        // Nonzero blank cell
        pulse_clr();
        do_tick(1'b1, 5'd0);
        do_tick(1'b1, 5'h05);
        do_tick(1'b1, 5'h05);
        do_tick(1'b1, 5'h05);
        check("blank_pre_ferr", frame_err, 0);
        do_tick(1'b1, 5'h01);
        do_tick(1'b1, 5'd0);
        do_tick(1'b0, 5'd0);
        check("blank_ferr", frame_err, 1);
        check("blank_total", char_total, 1);

        // WAIT drop at phase 2, then re-arm
        pulse_clr();
        popped.delete();
        do_tick(1'b1, 5'd0);
        do_tick(1'b1, 5'h09);
        do_tick(1'b1, 5'h09);
        do_tick(1'b0, 5'h09);
        idle(2);
        check("drop_total", char_total, 0);
        check("drop_ferr", frame_err, 0);
        do_tick(1'b1, 5'd0);
        send_cell(5'h0C);
        do_tick(1'b0, 5'd0);
        idle(2);
        check("rearm_total", char_total, 1);
        check("rearm_data", popped.size() == 1 ? popped[0] : 6'h3F, 6'h2C);

        // Reset mid-cell with data buffered
        char_ready = 1'b0;
        do_tick(1'b1, 5'd0);
        send_cell(5'h06);
        do_tick(1'b1, 5'h04);
        do_tick(1'b1, 5'h04);
        check("prerst_valid", char_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_valid", char_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_total", char_total, 0);
        check("rst_flags", {match_seen, overflow, frame_err}, 0);
        check("rst_data", char_data, 0);
        rst = 1'b0;
        do_tick(1'b1, 5'h04);
        check("postrst_valid", char_valid, 0);
        check("postrst_total", char_total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
